hvac_sequencer: RTL

- Central controller for the shared heating/cooling plant in the home automation design.
- Takes cool and heat requests from the thermostat logic, plus the window-open and enable inputs.
- Sequences the AC compressor, heater and fan with a minimum run time, a fan purge, and a changeover dead time.
- Guarantees AC and heater are never on together and that the plant is off while a window is open.

---
 rtl/hvac_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/hvac_sequencer.sv
// hvac_sequencer: heating/cooling plant sequencer.
// Drives AC, heater and fan with min run, fan purge and dead time.
module hvac_sequencer #(
   parameter int MIN_RUN   = 10,
   parameter int FAN_PURGE = 3,
   parameter int DEAD_TIME = 4,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             cool_req,
   input  logic             heat_req,
   input  logic             window_open,
   output logic             ac_on,
   output logic             heater_on,
   output logic             fan_on,
   output logic             inhibit,
   output logic             conflict,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] run_count
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COOL    = 3'd1,
      S_HEAT    = 3'd2,
      S_PURGE   = 3'd3,
      S_DEAD    = 3'd4,
      S_INHIBIT = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] RUN_LD   = CNT_W'(MIN_RUN - 1);
   localparam logic [CNT_W-1:0] PURGE_LD = CNT_W'(FAN_PURGE - 1);
   localparam logic [CNT_W-1:0] DEAD_LD  = CNT_W'(DEAD_TIME - 1);

   state_t           st;
   logic [CNT_W-1:0] timer;
   logic             tdone;

   assign tdone = (timer == '0);

   // Sequencer FSM; drives are registered copies decoded from st.
   always_ff @(posedge clk) begin
      if (reset) begin
         st        <= S_IDLE;
         timer     <= '0;
         run_count <= '0;
         ac_on     <= 1'b0;
         heater_on <= 1'b0;
         fan_on    <= 1'b0;
         inhibit   <= 1'b0;
         conflict  <= 1'b0;
         state     <= 3'd0;
      end else begin
         ac_on     <= (st == S_COOL);
         heater_on <= (st == S_HEAT);
         fan_on    <= (st == S_COOL) || (st == S_HEAT)
                   || (st == S_PURGE);
         inhibit   <= (st == S_INHIBIT);
         state     <= st;
         conflict  <= 1'b0;
         if (!tdone) timer <= timer - 1'b1;
         case (st)
            S_IDLE: begin
               if (window_open) begin
                  st <= S_INHIBIT;
               end else if (enable) begin
                  if (cool_req && !heat_req) begin
                     st    <= S_COOL;
                     timer <= RUN_LD;
                  end else if (heat_req && !cool_req) begin
                     st    <= S_HEAT;
                     timer <= RUN_LD;
                  end else if (cool_req && heat_req) begin
                     conflict <= 1'b1;
                  end
               end
            end
            S_COOL: begin
               if (window_open || (tdone &&
                   (!cool_req || heat_req || !enable))) begin
                  st    <= S_PURGE;
                  timer <= PURGE_LD;
                  if (run_count != '1)
                     run_count <= run_count + 1'b1;
               end
            end
            S_HEAT: begin
               if (window_open || (tdone &&
                   (!heat_req || cool_req || !enable))) begin
                  st    <= S_PURGE;
                  timer <= PURGE_LD;
                  if (run_count != '1)
                     run_count <= run_count + 1'b1;
               end
            end
            S_PURGE: begin
               if (tdone) begin
                  st    <= S_DEAD;
                  timer <= DEAD_LD;
               end
            end
            S_DEAD: begin
               if (tdone)
                  st <= window_open ? S_INHIBIT : S_IDLE;
            end
            S_INHIBIT: begin
               if (!window_open) st <= S_IDLE;
            end
            default: st <= S_IDLE;
         endcase
      end
   end

endmodule
